ldl_sfifo_ctrl: RTL and testbench
=================================

LDL_SFIFO_CTRL -- requirements
Module: LDL_sfifo_ctrl

Interface
REQ-001 Parameter DWIDTH, default 8: data width of the RAM and FIFO words.
REQ-002 Parameter AWIDTH, default 4: RAM address width; DEPTH = 2**AWIDTH words.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rstn.
REQ-004 Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- push  in  1  write request.
- din  in  DWIDTH  write data.
- full  out  1  FIFO holds DEPTH words.
- pop  in  1  read request.
- dout  out  DWIDTH  read data; driven directly from doutb.
- empty  out  1  no readable word.
- count  out  AWIDTH+1  total words held, 0..DEPTH.
- wea  out  1  RAM write enable.
- addra  out  AWIDTH  RAM write address.
- dina  out  DWIDTH  RAM write data.
- reb  out  1  RAM read enable.
- addrb  out  AWIDTH  RAM read address.
- doutb  in  DWIDTH  RAM registered read data; valid 1 cycle after reb.

Function
REQ-005 Push accept = push && !full; pop accept = pop && !empty; a request that is not accepted SHALL be ignored, with no state change.
REQ-006 wea, addra and dina SHALL be combinational: wea = push accept, addra = wptr, dina = din; on a push accept, wptr increments modulo DEPTH.
REQ-007 reb and addrb SHALL be combinational: addrb = rptr; each reb increments rptr modulo DEPTH; pointers wrap from DEPTH-1 to 0.
REQ-008 count SHALL be registered: +1 on push accept only, -1 on pop accept only, unchanged when both or neither are accepted.
REQ-009 full SHALL equal (count == DEPTH), registered.
REQ-010 Simultaneous push and pop while full: the pop is accepted and the push is rejected, because full gates push.
REQ-011 Simultaneous push and pop while empty: the push is accepted and the pop is rejected.
REQ-012 Standard mode (macro undefined):
- reb = pop accept.
- empty = (count == 0).
- dout is valid in the cycle after the pop accept.
- A word pushed in cycle N is poppable from cycle N+1.
REQ-013 FWFT mode (macro defined), two-state machine on the head register:
- States: HEAD_EMPTY (no valid head on doutb) and HEAD_VALID (doutb holds the unconsumed head).
- ram_cnt = count minus 1 if HEAD_VALID, else count.
- reb = (ram_cnt != 0) && (HEAD_EMPTY || pop accept).
- Next state = HEAD_VALID if reb; otherwise HEAD_EMPTY if pop accept; otherwise unchanged.
- empty = HEAD_EMPTY; dout is valid whenever !empty, without a pop.
- A word pushed into an empty FIFO in cycle N appears on dout and deasserts empty in cycle N+2.
REQ-014 FWFT back-to-back pops SHALL sustain 1 word per clock while ram_cnt > 0.

Reset
REQ-015 rstn low SHALL asynchronously clear wptr, rptr and count, force full=0, empty=1 and state HEAD_EMPTY; wea and reb are 0 while reset is held.
REQ-016 dout has no reset value: it is undefined until the first read, and RAM contents are not cleared.
REQ-017 Reset asserted mid-operation SHALL discard all stored words; the first push after release writes address 0.

Configuration
REQ-018 Macro LDL_SFIFO_FWFT_EN: when defined, FWFT mode (REQ-013/014) is compiled in; when undefined, standard mode (REQ-012) is used and the state machine is absent.

Verification (DWIDTH=8, AWIDTH=2, DEPTH=4)
REQ-019 Fill test: push 0x11,0x22,0x33,0x44 -> count=4, full=1; a fifth push of 0x55 -> wea=0, count stays 4.
REQ-020 Drain test, standard mode: pop 4 times -> dout = 0x11,0x22,0x33,0x44 one cycle after each pop, empty=1 after the last; a fifth pop -> reb=0, count stays 0.
REQ-021 Latency test, FWFT mode: push 0xA5 into an empty FIFO at cycle N -> empty=0 and dout=0xA5 at cycle N+2; pop -> empty=1 next cycle.
REQ-022 Wrap test: push and pop alternately for 10 words 0x00..0x09 -> output order preserved, addra/addrb wrap from 3 to 0, count never exceeds 1 in standard mode.
REQ-023 Simultaneous test: with count=2 (FWFT, head valid), push 0x77 and pop in the same cycle for 3 cycles -> count stays 2, dout advances 1 word per clock.
REQ-024 Reset test: with count=3, pulse rstn low mid-cycle -> count=0, empty=1, full=0 immediately; the next push writes addra=0.

Source files
------------

// File: rtl/ldl_sfifo_ctrl.sv
// ============================================================================
// ldl_sfifo_ctrl
// ----------------------------------------------------------------------------
// Single-clock synchronous FIFO controller that drives an external simple
// dual-port RAM. The RAM has a registered read port, so read data on doutb
// arrives one cycle after reb. The controller owns the write and read
// pointers, the word count and the full/empty flags.
//
// Build option:
//   LDL_SFIFO_FWFT_EN  - when defined, first-word-fall-through mode. The head
//                        word is prefetched into the RAM output register, so
//                        dout is valid whenever empty is low. When undefined,
//                        standard mode: dout is valid the cycle after a pop.
//
// Parameters:
//   DWIDTH - data width of the RAM and FIFO words
//   AWIDTH - RAM address width, DEPTH = 2**AWIDTH words
//
// Ports:
//   clk    in   clock, rising edge
//   rstn   in   asynchronous active-low reset
//   push   in   write request
//   din    in   write data
//   full   out  FIFO holds DEPTH words
//   pop    in   read request
//   dout   out  read data, taken straight from doutb
//   empty  out  no readable word
//   count  out  total words held, 0..DEPTH
//   wea    out  RAM write enable
//   addra  out  RAM write address
//   dina   out  RAM write data
//   reb    out  RAM read enable
//   addrb  out  RAM read address
//   doutb  in   RAM registered read data
// ============================================================================
module ldl_sfifo_ctrl #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    output logic              full,
    input  logic              pop,
    output logic [DWIDTH-1:0] dout,
    output logic              empty,
    output logic [AWIDTH:0]   count,
    output logic              wea,
    output logic [AWIDTH-1:0] addra,
    output logic [DWIDTH-1:0] dina,
    output logic              reb,
    output logic [AWIDTH-1:0] addrb,
    input  logic [DWIDTH-1:0] doutb
);

    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(1) << AWIDTH;

    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              pushAcc;
    logic              popAcc;

    // Accepts are gated by rstn so that wea and reb stay low while reset is held.
    // full gates push and empty gates pop, which settles the full/empty
    // simultaneous-request corner cases without extra logic.
    assign pushAcc = rstn && push && !full_q;
    assign popAcc  = rstn && pop && !empty;

    assign wea   = pushAcc;
    assign addra = wptr_q;
    assign dina  = din;
    assign addrb = rptr_q;
    assign dout  = doutb;
    assign full  = full_q;
    assign count = count_q;

    // Next-state for pointers, count and full. Pointers wrap naturally because
    // DEPTH is a power of two. full is computed from the next count so it is
    // registered alongside it.
    always_comb begin
        wptr_d = wptr_q;
        if (pushAcc) begin
            wptr_d = wptr_q + 1'b1;
        end
        rptr_d = rptr_q;
        if (reb) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q;
        if (pushAcc && !popAcc) begin
            count_d = count_q + 1'b1;
        end else if (!pushAcc && popAcc) begin
            count_d = count_q - 1'b1;
        end
        full_d = (count_d == DEPTH_C);
    end

    // Pointer and occupancy registers. Reset discards every stored word; the
    // RAM itself is left untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

`ifdef LDL_SFIFO_FWFT_EN

    typedef enum logic {
        HEAD_EMPTY = 1'b0,
        HEAD_VALID = 1'b1
    } head_state_e;

    head_state_e     state_q, state_d;
    logic [AWIDTH:0] ramCnt;

    // count includes the head word sitting in the RAM output register, so the
    // words still waiting inside the RAM are count minus that head. A fetch is
    // issued whenever the RAM has a word and the head slot is free or being
    // consumed this cycle, which gives one word per clock on back-to-back pops.
    always_comb begin
        ramCnt  = (state_q == HEAD_VALID) ? (count_q - 1'b1) : count_q;
        reb     = rstn && (ramCnt != '0) && ((state_q == HEAD_EMPTY) || popAcc);
        state_d = state_q;
        if (reb) begin
            state_d = HEAD_VALID;
        end else if (popAcc) begin
            state_d = HEAD_EMPTY;
        end
    end

    // Head-register state machine; empty is a direct decode of the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HEAD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign empty = (state_q == HEAD_EMPTY);

`else

    // Standard mode: each accepted pop reads the RAM directly and the data
    // appears on dout the following cycle.
    assign reb   = popAcc;
    assign empty = (count_q == '0);

`endif

endmodule

// File: tb/tb_ldl_sfifo_ctrl.sv
// ============================================================================
// tb_ldl_sfifo_ctrl
// ----------------------------------------------------------------------------
// Bench for ldl_sfifo_ctrl with DWIDTH=8, AWIDTH=2 (DEPTH=4). It includes a
// behavioural RAM with a registered read port. The reference model is a queue
// of words; each word remembers the cycle it was pushed so that the
// first-word-fall-through visibility rule (visible two cycles after its push)
// can be expressed directly. Expected read data is queued by the driver and
// checked by an independent monitor when the DUT presents data.
// Build option LDL_SFIFO_FWFT_EN selects the matching expectations.
// ============================================================================
`timescale 1ns/1ps
module tb_ldl_sfifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          push = 1'b0;
    logic          pop  = 1'b0;
    logic [DW-1:0] din  = '0;
    logic          full;
    logic [DW-1:0] dout;
    logic          empty;
    logic [AW:0]   count;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          reb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;

    always #5 clk = ~clk;

    ldl_sfifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (din),
        .full  (full),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .count (count),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .reb   (reb),
        .addrb (addrb),
        .doutb (doutb)
    );

    // Behavioural RAM: synchronous write, registered read, contents never reset.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        if (reb) doutb <= mem[addrb];
    end

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } entry_t;

    entry_t     modelQ[$];
    logic [7:0] expQ[$];
    int         compared   = 0;
    int         mismatched = 0;
    int         cyc        = 0;
    int         wAddr      = 0;
    int         rAddr      = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // A word is readable once it is in the queue; in fall-through mode the
    // head only becomes visible two cycles after its push.
    function automatic bit modelEmpty();
`ifdef LDL_SFIFO_FWFT_EN
        return (modelQ.size() == 0) || (modelQ[0].cyc + 2 > cyc);
`else
        return (modelQ.size() == 0);
`endif
    endfunction

    // Drive one cycle of requests, check the cycle's outputs, then advance the model.
    task automatic applyStimulus(input bit p, input logic [7:0] d, input bit q);
        bit pAcc;
        bit qAcc;
        @(negedge clk);
        push = p;
        din  = d;
        pop  = q;
        #1;
        pAcc = p && (modelQ.size() < DEPTH);
        qAcc = q && !modelEmpty();
        checkOutput("count", 32'(count), 32'(modelQ.size()));
        checkOutput("full", 32'(full), 32'(modelQ.size() == DEPTH));
        checkOutput("empty", 32'(empty), 32'(modelEmpty()));
        checkOutput("wea", 32'(wea), 32'(pAcc));
        checkOutput("addra", 32'(addra), 32'(wAddr));
        if (pAcc) checkOutput("dina", 32'(dina), 32'(d));
`ifndef LDL_SFIFO_FWFT_EN
        checkOutput("reb", 32'(reb), 32'(qAcc));
        checkOutput("addrb", 32'(addrb), 32'(rAddr));
`endif
        if (qAcc) begin
            expQ.push_back(modelQ[0].data);
            void'(modelQ.pop_front());
            rAddr = (rAddr + 1) % DEPTH;
        end
        if (pAcc) begin
            modelQ.push_back('{data: d, cyc: cyc});
            wAddr = (wAddr + 1) % DEPTH;
        end
        cyc++;
    endtask

    task automatic drainAll();
        for (int i = 0; i < 40 && modelQ.size() != 0; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    // Mid-cycle reset pulse while requests are asserted.
    task automatic pulseReset();
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        @(negedge clk);
        #3;
        rstn = 1'b0;
        push = 1'b1;
        pop  = 1'b1;
        din  = 8'hEE;
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_wea", 32'(wea), 32'd0);
        checkOutput("rst_reb", 32'(reb), 32'd0);
        modelQ.delete();
        wAddr = 0;
        rAddr = 0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        cyc += 3;
    endtask

`ifdef LDL_SFIFO_FWFT_EN
    // Fall-through monitor: data is consumed whenever the DUT shows a head
    // word and a pop is requested.
    always @(negedge clk) begin
        #2;
        if (rstn && pop && !empty) begin
            checkOutput("rd_pending", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) checkOutput("dout", 32'(dout), 32'(expQ.pop_front()));
        end
    end
`else
    // Standard monitor: data is presented the cycle after the DUT pulses reb.
    logic rdPend;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) rdPend <= 1'b0;
        else       rdPend <= reb;
    end
    always @(negedge clk) begin
        if (rdPend === 1'b1) begin
            checkOutput("rd_pending", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) checkOutput("dout", 32'(dout), 32'(expQ.pop_front()));
        end
    end
`endif

    initial begin
        int unsigned pushPct;
        int unsigned popPct;

        // Reset held from time zero with requests asserted.
        push = 1'b1;
        pop  = 1'b1;
        din  = 8'hEE;
        #2;
        checkOutput("init_count", 32'(count), 32'd0);
        checkOutput("init_empty", 32'(empty), 32'd1);
        checkOutput("init_full", 32'(full), 32'd0);
        checkOutput("init_wea", 32'(wea), 32'd0);
        checkOutput("init_reb", 32'(reb), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        push = 1'b0;
        pop  = 1'b0;

        $display("[TB] fill: four words then a rejected fifth push");
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] drain: four pops then a rejected fifth pop");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] latency: single word into an empty FIFO");
        applyStimulus(1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);

        $display("[TB] wrap: alternating push and pop of ten words");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        drainAll();

        $display("[TB] simultaneous push and pop at count two");
        applyStimulus(1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 8'h02, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h77, 1'b1);
        drainAll();

        $display("[TB] reset with three words stored");
        applyStimulus(1'b1, 8'hC1, 1'b0);
        applyStimulus(1'b1, 8'hC2, 1'b0);
        applyStimulus(1'b1, 8'hC3, 1'b0);
        pulseReset();
        applyStimulus(1'b1, 8'hD0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        drainAll();

        $display("[TB] randomized traffic");
        for (int ph = 0; ph < 4; ph++) begin
            pushPct = (ph % 2 == 0) ? 32'd75 : 32'd30;
            popPct  = (ph % 2 == 0) ? 32'd35 : 32'd80;
            for (int i = 0; i < 100; i++) begin
                applyStimulus($urandom_range(0, 99) < pushPct, 8'($urandom),
                              $urandom_range(0, 99) < popPct);
            end
        end
        drainAll();
        checkOutput("all_reads_seen", 32'(expQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
